// File: rtl/spike_packetizer.sv
// Scans a latched spike vector and emits one {CORE_ID, index} packet per set bit through a FWFT FIFO.
// Optional feature macro: SPIKE_PKT_COUNT_EN adds spike_count_o (packets pushed in the current frame).
module spike_packetizer #(
    parameter int          NUM_NEURONS = 256,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [0:0]  CORE_ID     = 1'b0,
    localparam int         IDX_W       = $clog2(NUM_NEURONS),
    localparam int         PTR_W       = $clog2(FIFO_DEPTH),
    localparam int         LVL_W       = PTR_W + 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   capture_i,
    input  logic [NUM_NEURONS-1:0] spike_vec_i,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output logic [IDX_W:0]         pkt_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overrun_o,
    input  logic                   clear_overrun_i,
    output logic [LVL_W-1:0]       fifo_level_o
`ifdef SPIKE_PKT_COUNT_EN
    ,
    output logic [IDX_W:0]         spike_count_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [NUM_NEURONS-1:0] frame_r;
    logic [IDX_W:0]         idx_r, idx_s, idx_inc_s;
    logic [IDX_W:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]       level_r;
    logic                   busy_r, done_r, overrun_r;
    logic                   full_s, empty_s, push_s, pop_s, accept_s, done_s;
    logic                   overrun_set_s, cur_bit_s;

    // Scan FSM next-state: one bit per cycle, stalling on a set bit while the FIFO is full.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        push_s        = 1'b0;
        accept_s      = 1'b0;
        done_s        = 1'b0;
        empty_s       = (level_r == {LVL_W{1'b0}});
        full_s        = (level_r == LVL_W'(FIFO_DEPTH));
        pop_s         = !empty_s && pkt_ready_i;
        cur_bit_s     = frame_r[idx_r[IDX_W-1:0]];
        idx_inc_s     = idx_r + {{IDX_W{1'b0}}, 1'b1};
        overrun_set_s = capture_i && (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (capture_i) begin
                    accept_s = 1'b1;
                    idx_s    = '0;
                    state_s  = SCAN;
                end else begin
                    state_s  = IDLE;
                end
            end
            SCAN: begin
                if (cur_bit_s && full_s) begin
                    idx_s = idx_r;
                end else begin
                    push_s = cur_bit_s;
                    idx_s  = idx_inc_s;
                    // The extra index bit marks that the last neuron has been passed.
                    if (idx_inc_s[IDX_W]) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = SCAN;
                    end
                end
            end
            DRAIN: begin
                if (empty_s) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, frame latch and status flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            frame_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= done_s;
            if (accept_s) begin
                frame_r <= spike_vec_i;
            end
            // A collision between set and clear keeps the flag raised.
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (clear_overrun_i) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Packet FIFO storage, pointers and occupancy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {CORE_ID, idx_r[IDX_W-1:0]};
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

`ifdef SPIKE_PKT_COUNT_EN
    logic [IDX_W:0] count_r;

    // Per-frame packet counter, held after completion until the next accepted capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_r <= '0;
        end else if (accept_s) begin
            count_r <= '0;
        end else if (push_s) begin
            count_r <= count_r + {{IDX_W{1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign spike_count_o = count_r;
`endif

    assign pkt_valid_o  = (level_r != {LVL_W{1'b0}});
    assign pkt_data_o   = mem_r[rd_ptr_r];
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign overrun_o    = overrun_r;
    assign fifo_level_o = level_r;

endmodule

// File: tb/tb_spike_packetizer.sv
// Bench for spike_packetizer: two instances (CORE_ID 0 and 1) share stimulus and are checked
// every cycle against a queue-based model, plus directed literal expectations.
module tb_spike_packetizer;

    localparam int N     = 256;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst, cap, ready, clr;
    logic [N-1:0] vec;

    logic         v0, b0, dn0, o0, v1, b1, dn1, o1;
    logic [8:0]   d0, d1;
    logic [4:0]   l0, l1;
`ifdef SPIKE_PKT_COUNT_EN
    logic [8:0]   c0, c1;
`endif

    spike_packetizer #(.NUM_NEURONS(N), .FIFO_DEPTH(DEPTH), .CORE_ID(1'b0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .capture_i(cap), .spike_vec_i(vec),
        .pkt_valid_o(v0), .pkt_ready_i(ready), .pkt_data_o(d0), .busy_o(b0),
        .done_o(dn0), .overrun_o(o0), .clear_overrun_i(clr), .fifo_level_o(l0)
`ifdef SPIKE_PKT_COUNT_EN
        , .spike_count_o(c0)
`endif
    );

    spike_packetizer #(.NUM_NEURONS(N), .FIFO_DEPTH(DEPTH), .CORE_ID(1'b1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .capture_i(cap), .spike_vec_i(vec),
        .pkt_valid_o(v1), .pkt_ready_i(ready), .pkt_data_o(d1), .busy_o(b1),
        .done_o(dn1), .overrun_o(o1), .clear_overrun_i(clr), .fifo_level_o(l1)
`ifdef SPIKE_PKT_COUNT_EN
        , .spike_count_o(c1)
`endif
    );

    always #5 clk = ~clk;

    // Model: a frame is a bit set, the FIFO is a queue of neuron indices.
    int     q[$];
    bit     m_busy = 1'b0;
    int     m_pos = 0;
    bit [N-1:0] m_frame = '0;
    bit     m_ovr = 1'b0;
    bit     m_done = 1'b0;
    int     m_cnt = 0;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     hs0[$];
    int     hs1[$];
    int     done_cnt = 0;
    int     last_done_cyc = -1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int sz;
        bit pop_m, full_m, push_m;
        int push_idx;
        if (rst) begin
            q.delete();
            m_busy = 1'b0; m_pos = 0; m_frame = '0;
            m_ovr = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else begin
            sz       = q.size();
            pop_m    = (sz != 0) && ready;
            full_m   = (sz == DEPTH);
            push_m   = 1'b0;
            push_idx = 0;
            m_done   = 1'b0;
            if (!m_busy) begin
                if (cap) begin
                    m_frame = vec; m_pos = 0; m_busy = 1'b1; m_cnt = 0;
                end
            end else if (m_pos < N) begin
                if (!(m_frame[m_pos] && full_m)) begin
                    if (m_frame[m_pos]) begin
                        push_m = 1'b1; push_idx = m_pos; m_cnt++;
                    end
                    m_pos++;
                end
            end else if (sz == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
            end
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(push_idx);
            if (cap && m_busy && !(m_pos == 0 && push_m == 1'b0 && cap && m_frame == vec && m_cnt == 0 && 1'b0)) begin
            end
        end
    endtask

    // Overrun is judged from the busy state before the edge, so it is computed outside model_step.
    task automatic cycle();
        bit was_busy;
        if (v0 === 1'b1 && ready === 1'b1) hs0.push_back(int'(d0));
        if (v1 === 1'b1 && ready === 1'b1) hs1.push_back(int'(d1));
        was_busy = m_busy;
        model_step();
        if (!rst) begin
            if (cap && was_busy) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("valid0", int'(v0), int'(q.size() != 0));
        check("valid1", int'(v1), int'(q.size() != 0));
        check("level0", int'(l0), q.size());
        check("level1", int'(l1), q.size());
        check("busy0", int'(b0), int'(m_busy));
        check("busy1", int'(b1), int'(m_busy));
        check("done0", int'(dn0), int'(m_done));
        check("done1", int'(dn1), int'(m_done));
        check("overrun0", int'(o0), int'(m_ovr));
        check("overrun1", int'(o1), int'(m_ovr));
        if (q.size() != 0) begin
            check("data0", int'(d0), q[0]);
            check("data1", int'(d1), 256 + q[0]);
        end
`ifdef SPIKE_PKT_COUNT_EN
        check("count0", int'(c0), m_cnt);
        check("count1", int'(c1), m_cnt);
`endif
        if (dn0 === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (dn0 !== 1'b1 && n < limit) begin
            cycle();
            n++;
        end
        check("done_timeout", int'(dn0 === 1'b1), 1);
    endtask

    task automatic start_frame(output int t);
        hs0.delete(); hs1.delete(); done_cnt = 0;
        t = cyc;
        cap = 1'b1;
        cycle();
        cap = 1'b0;
    endtask

    initial begin
        int t;
        int errs;
        int n;
        rst = 1'b1; cap = 1'b1; vec = '1; ready = 1'b0; clr = 1'b0;

        // Reset held two cycles with capture asserted.
        cycle(); cycle();
        check("rst_valid", int'(v0), 0);
        check("rst_data", int'(d0), 0);
        check("rst_busy", int'(b0), 0);
        check("rst_done", int'(dn0), 0);
        check("rst_ovr", int'(o0), 0);
        check("rst_level", int'(l0), 0);
        rst = 1'b0; cap = 1'b0;
        cycle();
        check("post_rst_busy", int'(b0), 0);

        // Basic frame: bits 3, 200, 255 with ready held high.
        ready = 1'b1;
        vec = '0; vec[3] = 1'b1; vec[200] = 1'b1; vec[255] = 1'b1;
        start_frame(t);
        check("basic_busy_t1", int'(b0), 1);
        wait_done(400);
`ifdef SPIKE_PKT_COUNT_EN
        check("basic_count", int'(c0), 3);
`endif
        cycle();
        check("basic_npkt", hs0.size(), 3);
        if (hs0.size() == 3) begin
            check("basic_p0", hs0[0], 'h003);
            check("basic_p1", hs0[1], 'h0C8);
            check("basic_p2", hs0[2], 'h0FF);
        end
        check("basic_done_cnt", done_cnt, 1);
        check("basic_done_lat", last_done_cyc - t, 259);

        // Empty frame completes at t+258.
        vec = '0;
        start_frame(t);
        wait_done(400);
        check("empty_done_lat", last_done_cyc - t, 258);
        check("empty_npkt", hs0.size(), 0);

        // Backpressure: all ones, consumer stalled for 100 cycles.
        ready = 1'b0; vec = '1;
        start_frame(t);
        repeat (99) cycle();
        check("bp_level", int'(l0), 16);
        check("bp_busy", int'(b0), 1);
        ready = 1'b1;
        wait_done(2000);
        check("bp_npkt", hs0.size(), 256);
        errs = 0;
        for (int i = 0; i < hs0.size(); i++) if (hs0[i] != i) errs++;
        check("bp_seq", errs, 0);

        // Overrun: second capture while scanning index 50 is ignored.
        vec = '0; vec[10] = 1'b1; vec[60] = 1'b1; vec[100] = 1'b1;
        start_frame(t);
        repeat (50) cycle();
        vec = '0; vec[20] = 1'b1; vec[70] = 1'b1;
        cap = 1'b1;
        cycle();
        cap = 1'b0;
        check("ovr_set", int'(o0), 1);
        wait_done(400);
        check("ovr_npkt", hs0.size(), 3);
        if (hs0.size() == 3) begin
            check("ovr_p0", hs0[0], 10);
            check("ovr_p1", hs0[1], 60);
            check("ovr_p2", hs0[2], 100);
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("ovr_clear", int'(o0), 0);
        vec = '0; vec[5] = 1'b1;
        start_frame(t);
        cap = 1'b1; clr = 1'b1;
        cycle();
        cap = 1'b0; clr = 1'b0;
        check("ovr_collide", int'(o0), 1);
        wait_done(400);
        clr = 1'b1;
        cycle();
        clr = 1'b0;

        // Mid-frame reset after five packets.
        vec = '1;
        start_frame(t);
        n = 0;
        while (hs0.size() < 5 && n < 60) begin
            cycle();
            n++;
        end
        check("mid_reach5", int'(hs0.size() >= 5), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_valid", int'(v0), 0);
        check("mid_level", int'(l0), 0);
        check("mid_busy", int'(b0), 0);
        vec = '0; vec[9] = 1'b1;
        start_frame(t);
        wait_done(400);
        cycle();
        check("mid_npkt", hs0.size(), 1);
        if (hs0.size() == 1) check("mid_p0", hs0[0], 'h009);

        // CORE_ID=1 instance and packet counter.
        vec = '0; vec[0] = 1'b1; vec[7] = 1'b1;
        start_frame(t);
        wait_done(400);
`ifdef SPIKE_PKT_COUNT_EN
        check("cnt_at_done", int'(c1), 2);
`endif
        repeat (3) cycle();
`ifdef SPIKE_PKT_COUNT_EN
        check("cnt_held", int'(c1), 2);
`endif
        check("cid_npkt", hs1.size(), 2);
        if (hs1.size() == 2) begin
            check("cid_p0", hs1[0], 'h100);
            check("cid_p1", hs1[1], 'h107);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
